morse_symbol_timer: RTL and testbench

//  Upstream stage of the 5-bit Morse symbol shift register. Times the key input, classifies each

---
 rtl/morse_symbol_timer.sv | 159 +++++++++++++++
 tb/tb_morse_symbol_timer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_timer.sv
// Morse key timer: times key presses and gaps, classifies dot/dash,
// and frames symbols into letters and words for the shift register.
module morse_symbol_timer #(
    parameter int TICK_DIV         = 50_000,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7,
    parameter int UNIT_W           = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key,
    output logic       shift,
    output logic       si,
    output logic       clear,
    output logic       letter_valid,
    output logic [2:0] sym_count,
    output logic       overflow,
    output logic       word_gap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PMAX   = PW'(TICK_DIV - 1);
    localparam logic [UNIT_W-1:0] UMAX   = '1;
    localparam logic [UNIT_W-1:0] DASH_U = UNIT_W'(DASH_UNITS);
    localparam logic [UNIT_W-1:0] LGAP_U = UNIT_W'(LETTER_GAP_UNITS);
    localparam logic [UNIT_W-1:0] WGAP_U = UNIT_W'(WORD_GAP_UNITS);
    localparam logic [2:0]        MAXSYM = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        LGAP  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic key_m, key_s, key_d;
    logic rise, fall, key_edge;
    logic [PW-1:0] presc;
    logic [UNIT_W-1:0] units;
    logic tick;
    logic shift_nx, lv_nx, wg_nx, ovf_set;

    // key_m/key_s form the synchroniser; key_d holds the previous key_s
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
            key_d <= 1'b0;
        end else begin
            key_m <= key;
            key_s <= key_m;
            key_d <= key_s;
        end
    end

    assign rise     = key_s & ~key_d;
    assign fall     = ~key_s & key_d;
    assign key_edge = rise | fall;
    assign tick     = (presc == PMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            units <= '0;
        end else if (key_edge) begin
            presc <= '0;
            units <= '0;
        end else if (tick) begin
            presc <= '0;
            if (units != UMAX)
                units <= units + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        shift_nx = 1'b0;
        lv_nx    = 1'b0;
        wg_nx    = 1'b0;
        ovf_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise)
                    state_nx = PRESS;
            end
            PRESS: begin
                if (fall) begin
                    state_nx = GAP;
                    if (sym_count < MAXSYM)
                        shift_nx = 1'b1;
                    else
                        ovf_set = 1'b1;
                end
            end
            GAP: begin
                // a press landing on the threshold still closes the letter
                if (units == LGAP_U) begin
                    if (sym_count != 3'd0) begin
                        lv_nx    = 1'b1;
                        state_nx = rise ? PRESS : LGAP;
                    end else begin
                        state_nx = rise ? PRESS : IDLE;
                    end
                end else if (rise) begin
                    state_nx = PRESS;
                end
            end
            LGAP: begin
                if (rise) begin
                    state_nx = PRESS;
                end else if (units == WGAP_U) begin
                    wg_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift        <= 1'b0;
            si           <= 1'b0;
            letter_valid <= 1'b0;
            word_gap     <= 1'b0;
            clear        <= 1'b0;
            sym_count    <= 3'd0;
            overflow     <= 1'b0;
        end else begin
            shift        <= shift_nx;
            si           <= shift_nx & (units >= DASH_U);
            letter_valid <= lv_nx;
            word_gap     <= wg_nx;
            clear        <= letter_valid;
            if (letter_valid) begin
                sym_count <= shift_nx ? 3'd1 : 3'd0;
                overflow  <= ovf_set;
            end else begin
                if (shift_nx)
                    sym_count <= sym_count + 3'd1;
                if (ovf_set)
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Directed bench for morse_symbol_timer with a short prescaler.
// Pulse monitors count events; steps compare the deltas.
module tb_morse_symbol_timer;

    logic       clk;
    logic       reset_n;
    logic       key;
    logic       shift;
    logic       si;
    logic       clear;
    logic       letter_valid;
    logic [2:0] sym_count;
    logic       overflow;
    logic       word_gap;

    int n_cmp = 0;
    int n_err = 0;

    int n_shift = 0;
    int n_lv    = 0;
    int n_clr   = 0;
    int n_wg    = 0;
    int n_coll  = 0;
    logic [7:0] si_hist = '0;
    logic [2:0] lv_sym  = '0;
    logic       lv_ovf  = 1'b0;

    int b_shift, b_lv, b_clr, b_wg;

    morse_symbol_timer #(
        .TICK_DIV(4),
        .DASH_UNITS(3),
        .LETTER_GAP_UNITS(3),
        .WORD_GAP_UNITS(7),
        .UNIT_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key(key),
        .shift(shift),
        .si(si),
        .clear(clear),
        .letter_valid(letter_valid),
        .sym_count(sym_count),
        .overflow(overflow),
        .word_gap(word_gap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (shift) begin
            n_shift++;
            si_hist = {si_hist[6:0], si};
        end
        if (letter_valid) begin
            n_lv++;
            lv_sym = sym_count;
            lv_ovf = overflow;
        end
        if (clear)
            n_clr++;
        if (word_gap)
            n_wg++;
        if ((32'(shift) + 32'(clear) + 32'(letter_valid) + 32'(word_gap)) > 1)
            n_coll++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        key = v;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic mark();
        b_shift = n_shift;
        b_lv    = n_lv;
        b_clr   = n_clr;
        b_wg    = n_wg;
    endtask

    initial begin
        key     = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_shift", 32'(shift), 0);
        chk("rst_si", 32'(si), 0);
        chk("rst_clear", 32'(clear), 0);
        chk("rst_lv", 32'(letter_valid), 0);
        chk("rst_cnt", 32'(sym_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_wg", 32'(word_gap), 0);
        chk("rst_state", 32'(dut.state), 0);
        reset_n = 1'b1;
        hold(1'b0, 3);

        mark();
        hold(1'b1, 4);
        hold(1'b0, 6);
        chk("dot_shifts", 32'(n_shift - b_shift), 1);
        chk("dot_si", 32'(si_hist[0]), 0);
        chk("dot_cnt", 32'(sym_count), 1);
        hold(1'b0, 40);
        chk("dot_lv", 32'(n_lv - b_lv), 1);
        chk("dot_lv_cnt", 32'(lv_sym), 1);
        chk("dot_clr", 32'(n_clr - b_clr), 1);
        chk("dot_wg", 32'(n_wg - b_wg), 1);
        chk("dot_idle", 32'(dut.state), 0);
        chk("dot_cnt0", 32'(sym_count), 0);

        mark();
        hold(1'b1, 14);
        hold(1'b0, 6);
        chk("dash_shifts", 32'(n_shift - b_shift), 1);
        chk("dash_si", 32'(si_hist[0]), 1);
        chk("dash_cnt", 32'(sym_count), 1);
        hold(1'b0, 40);

        mark();
        hold(1'b1, 4);
        hold(1'b0, 4);
        hold(1'b1, 14);
        hold(1'b0, 16);
        hold(1'b0, 4);
        chk("a_shifts", 32'(n_shift - b_shift), 2);
        chk("a_si", 32'(si_hist[1:0]), 1);
        chk("a_lv", 32'(n_lv - b_lv), 1);
        chk("a_lv_cnt", 32'(lv_sym), 2);
        chk("a_clr", 32'(n_clr - b_clr), 1);
        chk("a_cnt0", 32'(sym_count), 0);
        hold(1'b0, 30);

        mark();
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 4);
            hold(1'b0, 4);
        end
        hold(1'b0, 20);
        chk("ov_shifts", 32'(n_shift - b_shift), 5);
        chk("ov_lv", 32'(n_lv - b_lv), 1);
        chk("ov_lv_cnt", 32'(lv_sym), 5);
        chk("ov_lv_ovf", 32'(lv_ovf), 1);
        chk("ov_cnt0", 32'(sym_count), 0);
        chk("ov_ovf0", 32'(overflow), 0);
        hold(1'b0, 20);

        mark();
        hold(1'b1, 4);
        hold(1'b0, 18);
        hold(1'b1, 4);
        hold(1'b0, 6);
        chk("nw_lv", 32'(n_lv - b_lv), 1);
        chk("nw_wg", 32'(n_wg - b_wg), 0);
        chk("nw_shifts", 32'(n_shift - b_shift), 2);
        chk("nw_cnt", 32'(sym_count), 1);
        hold(1'b0, 40);

        mark();
        hold(1'b1, 80);
        hold(1'b0, 6);
        chk("sat_shifts", 32'(n_shift - b_shift), 1);
        chk("sat_si", 32'(si_hist[0]), 1);
        hold(1'b0, 40);

        mark();
        hold(1'b1, 4);
        hold(1'b0, 4);
        hold(1'b1, 4);
        hold(1'b0, 4);
        hold(1'b1, 6);
        chk("mr_cnt2", 32'(sym_count), 2);
        reset_n = 1'b0;
        key     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("mr_shift", 32'(shift), 0);
        chk("mr_cnt", 32'(sym_count), 0);
        chk("mr_lvo", 32'(letter_valid), 0);
        chk("mr_state", 32'(dut.state), 0);
        reset_n = 1'b1;
        b_shift = n_shift;
        b_lv    = n_lv;
        hold(1'b0, 40);
        chk("mr_lv", 32'(n_lv - b_lv), 0);
        chk("mr_shifts", 32'(n_shift - b_shift), 0);
        chk("mr_idle", 32'(dut.state), 0);

        chk("collisions", 32'(n_coll), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
